sha256_core: RTL and testbench

//  Single-block SHA-256 compression engine, one round per clock. Takes a 256-bit chaining

---
 rtl/sha256_if.sv | 23 ++
 rtl/sha256_core.sv | 151 +++++++++++++++
 tb/tb_sha256_core.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sha256_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_if
//  Purpose  : Handshake/data bundle between a hashing controller and the
//             SHA-256 compression core.
//  Revision : 1.0  initial release
// ============================================================================
interface sha256_if;
  logic         start;
  logic [255:0] start_state;
  logic [511:0] input_message;
  logic [255:0] result;
  logic         done;

  // Controller side: issues jobs, consumes the digest
  modport master (output start, output start_state, output input_message,
                  input  result, input  done);

  // Core side: accepts jobs, produces the digest
  modport slave  (input  start, input  start_state, input  input_message,
                  output result, output done);
endinterface
`default_nettype wire

// File: rtl/sha256_core.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_core
//  Purpose  : Single-block SHA-256 compression, one round per clock. Loads a
//             chaining state and a padded 512-bit block on start, runs 64
//             rounds, then adds the latched input state back in.
//  Revision : 1.0  initial release
// ============================================================================
module sha256_core (
  input  wire logic clk,
  input  wire logic rst,     // asynchronous, active-low
  sha256_if.slave   bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // K[0] sits in the most significant word, so K[t] = K_TAB[63-t]
  localparam logic [63:0][31:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    ror = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    big_s0 = ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    big_s1 = ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    small_s0 = ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    small_s1 = ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Word 7 = a/H0 ... word 0 = h/H7, matching the 256-bit port layout.
  // Schedule window: word 15 = W[t] (oldest) ... word 0 = W[t+15].
  logic [1:0]        state_q, state_d;
  logic [6:0]        round_q, round_d;
  logic [7:0][31:0]  work_q, work_d;
  logic [7:0][31:0]  h_in_q, h_in_d;
  logic [15:0][31:0] w_q, w_d;
  logic [255:0]      result_q, result_d;
  logic              done_q, done_d;

  logic              load, do_round, do_final;
  logic [31:0]       t1, t2, w_next, k_t;
  logic [7:0][31:0]  final_sum;

  // State register; reset aborts any job in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: start wins from any state; RUN ends after the finalise edge
  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (round_q[6]) state_d = ST_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs: datapath controls
  always_comb begin
    load     = bus.start;
    do_round = !bus.start && (state_q == ST_RUN) && !round_q[6];
    do_final = !bus.start && (state_q == ST_RUN) &&  round_q[6];
  end

  // Round function and on-the-fly message expansion
  always_comb begin
    k_t    = K_TAB[6'd63 - round_q[5:0]];
    t1     = work_q[0] + big_s1(work_q[3])
           + ((work_q[3] & work_q[2]) ^ (~work_q[3] & work_q[1]))
           + k_t + w_q[15];
    t2     = big_s0(work_q[7])
           + ((work_q[7] & work_q[6]) ^ (work_q[7] & work_q[5]) ^ (work_q[6] & work_q[5]));
    w_next = small_s1(w_q[1]) + w_q[6] + small_s0(w_q[14]) + w_q[15];
    for (int i = 0; i < 8; i++) final_sum[i] = h_in_q[i] + work_q[i];
  end

  // Datapath next-state: load on start, one round per RUN edge, then finalise
  always_comb begin
    round_d  = round_q;
    work_d   = work_q;
    h_in_d   = h_in_q;
    w_d      = w_q;
    result_d = result_q;
    done_d   = done_q;
    if (load) begin
      work_d  = bus.start_state;
      h_in_d  = bus.start_state;
      w_d     = bus.input_message;
      round_d = 7'd0;
      done_d  = 1'b0;
    end else if (do_round) begin
      work_d  = {t1 + t2, work_q[7], work_q[6], work_q[5],
                 work_q[4] + t1, work_q[3], work_q[2], work_q[1]};
      w_d     = {w_q[14:0], w_next};
      round_d = round_q + 7'd1;
    end else if (do_final) begin
      result_d = final_sum;
      done_d   = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      round_q  <= '0;
      work_q   <= '0;
      h_in_q   <= '0;
      w_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      round_q  <= round_d;
      work_q   <= work_d;
      h_in_q   <= h_in_d;
      w_q      <= w_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_core
//  Purpose  : Directed self-checking bench for sha256_core.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_core;

  localparam logic [255:0] IV        = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  sha256_if bus ();

  sha256_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    rr = (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression: full 64-word schedule expansion, then 64 rounds
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] x1, x2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    ref_compress = r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Drive one-cycle start; returns 1ns after the sampling edge
  task automatic launch(input logic [255:0] st, input logic [511:0] msg);
    @(negedge clk);
    bus.start         = 1'b1;
    bus.start_state   = st;
    bus.input_message = msg;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count rising edges after the start edge until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
    end
  endtask

  initial begin
    int           lat;
    logic         flag;
    logic [255:0] snap;
    logic [255:0] chain_exp;

    bus.start         = 1'b0;
    bus.start_state   = '0;
    bus.input_message = '0;
    rst               = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done",   {255'h0, bus.done}, 256'h0);
    chk("reset_result", bus.result,         256'h0);
    @(negedge clk);
    rst = 1'b1;

    // 1: "abc"
    launch(IV, ABC_BLK);
    wait_done(lat);
    chk("abc_latency", 256'(lat), 256'd65);
    chk("abc_digest",  bus.result, ABC_DIG);

    // 2: empty string
    launch(IV, EMPTY_BLK);
    wait_done(lat);
    chk("empty_latency", 256'(lat), 256'd65);
    chk("empty_digest",  bus.result, EMPTY_DIG);

    // 3: chaining from the abc digest, inputs scrambled right after start
    chain_exp = ref_compress(ABC_DIG, EMPTY_BLK);
    launch(ABC_DIG, EMPTY_BLK);
    bus.start_state   = {8{$urandom()}};
    bus.input_message = {16{$urandom()}};
    wait_done(lat);
    chk("chain_latency", 256'(lat), 256'd65);
    chk("chain_digest",  bus.result, chain_exp);

    // 4: hold in DONE, then restart
    snap = bus.result;
    flag = 1'b1;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (!bus.done || bus.result !== snap) flag = 1'b0;
    end
    chk("done_hold_stable", {255'h0, flag}, 256'h1);
    launch(IV, ABC_BLK);
    chk("done_low_after_start", {255'h0, bus.done}, 256'h0);
    wait_done(lat);
    chk("restart_latency", 256'(lat), 256'd65);
    chk("restart_digest",  bus.result, ABC_DIG);

    // 5: abandon a job at +30 with the empty-string block
    launch(IV, ABC_BLK);
    flag = 1'b0;
    repeat (29) begin
      @(posedge clk);
      #1;
      if (bus.done) flag = 1'b1;
    end
    launch(IV, EMPTY_BLK);
    if (bus.done) flag = 1'b1;
    chk("abort_no_early_done", {255'h0, flag}, 256'h0);
    wait_done(lat);
    chk("abort_latency", 256'(lat), 256'd65);
    chk("abort_digest",  bus.result, EMPTY_DIG);

    // 6: reset mid-run, checked before any further clock edge
    launch(IV, ABC_BLK);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_reset_done",   {255'h0, bus.done}, 256'h0);
    chk("midrun_reset_result", bus.result,         256'h0);
    @(posedge clk);
    #1;
    chk("reset_held_done", {255'h0, bus.done}, 256'h0);
    @(negedge clk);
    rst = 1'b1;
    launch(IV, EMPTY_BLK);
    wait_done(lat);
    chk("post_reset_latency", 256'(lat), 256'd65);
    chk("post_reset_digest",  bus.result, EMPTY_DIG);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
